// File: rtl/fifo8_pkg.sv
// Shared constants for the 8-entry FIFO control path, storage bank and read mux.
// The FSM state records what happened to last cycle's requests.
package fifo8_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_AW    = 3;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WRITE     = 3'd1;
   localparam logic [2:0] ST_READ      = 3'd2;
   localparam logic [2:0] ST_WR_RD     = 3'd3;
   localparam logic [2:0] ST_WR_ERR    = 3'd4;
   localparam logic [2:0] ST_RD_ERR    = 3'd5;
   localparam logic [2:0] ST_WR_ERR_RD = 3'd6;
   localparam logic [2:0] ST_WR_RD_ERR = 3'd7;

endpackage

// File: rtl/fifo8_ns_out.sv
// Next-state logic and status decode for the FIFO control FSM.
// Accept strobes come from the registered full/empty flags.
module fifo8_ns_out
   import fifo8_pkg::*;
(
   input  logic [2:0] state,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic       full,
   input  logic       empty,
   output logic [2:0] next_state,
   output logic       wr_ok,
   output logic       rd_ok,
   output logic       wr_ack,
   output logic       wr_err,
   output logic       rd_ack,
   output logic       rd_err
);

   always_comb begin
      wr_ok      = wr_en & ~full;
      rd_ok      = rd_en & ~empty;
      next_state = ST_IDLE;
      case ({wr_en, rd_en})
         2'b10: next_state = wr_ok ? ST_WRITE : ST_WR_ERR;
         2'b01: next_state = rd_ok ? ST_READ : ST_RD_ERR;
         2'b11: begin
            // full and empty together cannot occur, so 00 maps to IDLE
            case ({wr_ok, rd_ok})
               2'b11:   next_state = ST_WR_RD;
               2'b01:   next_state = ST_WR_ERR_RD;
               2'b10:   next_state = ST_WR_RD_ERR;
               default: next_state = ST_IDLE;
            endcase
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ack = 1'b0;
      wr_err = 1'b0;
      rd_ack = 1'b0;
      rd_err = 1'b0;
      case (state)
         ST_WRITE:     wr_ack = 1'b1;
         ST_READ:      rd_ack = 1'b1;
         ST_WR_RD:     begin wr_ack = 1'b1; rd_ack = 1'b1; end
         ST_WR_ERR:    wr_err = 1'b1;
         ST_RD_ERR:    rd_err = 1'b1;
         ST_WR_ERR_RD: begin wr_err = 1'b1; rd_ack = 1'b1; end
         ST_WR_RD_ERR: begin wr_ack = 1'b1; rd_err = 1'b1; end
         default:      ;
      endcase
   end

endmodule

// File: rtl/fifo8_ctrl.sv
// Control path for the 8x32 FIFO: pointers, occupancy, one-hot bank write
// enables, registered read-mux select and one-cycle-late ack/err status.
module fifo8_ctrl
   import fifo8_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [DEPTH-1:0] we,
   output logic [AW-1:0]    rd_sel,
   output logic [AW:0]      data_count,
   output logic             full,
   output logic             empty,
   output logic             wr_ack,
   output logic             wr_err,
   output logic             rd_ack,
   output logic             rd_err
);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW-1:0] rd_sel_q, rd_sel_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          wr_ok, rd_ok;

   fifo8_ns_out u_ns_out (
      .state      (state_q),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .full       (full_q),
      .empty      (empty_q),
      .next_state (state_d),
      .wr_ok      (wr_ok),
      .rd_ok      (rd_ok),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   // Bank captures d_in on the same edge the request is accepted.
   always_comb begin
      we = '0;
      if (reset_n && wr_ok)
         we = {{(DEPTH-1){1'b0}}, 1'b1} << tail_q;
   end

   always_comb begin
      tail_d   = wr_ok ? tail_q + AW'(1) : tail_q;
      head_d   = rd_ok ? head_q + AW'(1) : head_q;
      rd_sel_d = rd_ok ? head_q : rd_sel_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == (AW+1)'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         head_q   <= '0;
         tail_q   <= '0;
         rd_sel_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         rd_sel_q <= rd_sel_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign rd_sel     = rd_sel_q;
   assign data_count = count_q;
   assign full       = full_q;
   assign empty      = empty_q;

endmodule

// File: tb/tb_fifo8_ctrl.sv
// Bench for fifo8_ctrl: fixed vector table, targeted corner sequences and
// random traffic against a queue-based occupancy model.
module tb_fifo8_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] we;
   logic [2:0] rd_sel;
   logic [3:0] data_count;
   logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

   int checks = 0;
   int failures = 0;

   fifo8_ctrl #(.DEPTH(8), .AW(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .we         (we),
      .rd_sel     (rd_sel),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       w, r, rn;
      logic [7:0] we;
      logic [3:0] cnt;
      logic       full, empty, wack, werr, rack, rerr;
      logic [2:0] rsel;
   } vec_t;

   vec_t tbl[21];

   // Model: FIFO contents are the slot numbers they were written into.
   int q[$];
   int wslot = 0;
   int m_rsel = 0;
   bit m_wack = 0, m_werr = 0, m_rack = 0, m_rerr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic apply_vec(input int i);
      @(negedge clk);
      wr_en = tbl[i].w; rd_en = tbl[i].r; reset_n = tbl[i].rn;
      #1;
      chk($sformatf("vec%0d.we", i), int'(we), int'(tbl[i].we));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.count", i), int'(data_count), int'(tbl[i].cnt));
      chk($sformatf("vec%0d.full", i),  int'(full),   int'(tbl[i].full));
      chk($sformatf("vec%0d.empty", i), int'(empty),  int'(tbl[i].empty));
      chk($sformatf("vec%0d.wr_ack", i), int'(wr_ack), int'(tbl[i].wack));
      chk($sformatf("vec%0d.wr_err", i), int'(wr_err), int'(tbl[i].werr));
      chk($sformatf("vec%0d.rd_ack", i), int'(rd_ack), int'(tbl[i].rack));
      chk($sformatf("vec%0d.rd_err", i), int'(rd_err), int'(tbl[i].rerr));
      chk($sformatf("vec%0d.rd_sel", i), int'(rd_sel), int'(tbl[i].rsel));
   endtask

   task automatic mstep(input string tag, input logic w, input logic r, input logic rn);
      bit wok, rok;
      int exp_we;
      @(negedge clk);
      wr_en = w; rd_en = r; reset_n = rn;
      #1;
      wok = rn && w && (q.size() < 8);
      rok = rn && r && (q.size() > 0);
      exp_we = wok ? (1 << wslot) : 0;
      chk({tag, ".we"}, int'(we), exp_we);
      @(posedge clk); #1;
      if (!rn) begin
         q.delete(); wslot = 0; m_rsel = 0;
         m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
      end else begin
         if (rok) m_rsel = q.pop_front();
         if (wok) begin q.push_back(wslot); wslot = (wslot + 1) % 8; end
         m_wack = wok; m_werr = w && !wok;
         m_rack = rok; m_rerr = r && !rok;
      end
      chk({tag, ".count"}, int'(data_count), q.size());
      chk({tag, ".full"},  int'(full),  int'(q.size() == 8));
      chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
      chk({tag, ".wr_ack"}, int'(wr_ack), int'(m_wack));
      chk({tag, ".wr_err"}, int'(wr_err), int'(m_werr));
      chk({tag, ".rd_ack"}, int'(rd_ack), int'(m_rack));
      chk({tag, ".rd_err"}, int'(rd_err), int'(m_rerr));
      chk({tag, ".rd_sel"}, int'(rd_sel), m_rsel);
   endtask

   initial begin
      // reset with a pending write, idle, read from empty, fill, overflow, drain
      tbl[0] = '{1,0,0, 8'h00, 0, 0,1, 0,0,0,0, 0};
      tbl[1] = '{0,0,0, 8'h00, 0, 0,1, 0,0,0,0, 0};
      tbl[2] = '{0,0,1, 8'h00, 0, 0,1, 0,0,0,0, 0};
      tbl[3] = '{0,1,1, 8'h00, 0, 0,1, 0,0,0,1, 0};
      for (int i = 0; i < 8; i++)
         tbl[4+i] = '{1,0,1, 8'(1 << i), 4'(i+1), (i == 7), 0, 1,0,0,0, 0};
      tbl[12] = '{1,0,1, 8'h00, 8, 1,0, 0,1,0,0, 0};
      for (int k = 0; k < 8; k++)
         tbl[13+k] = '{0,1,1, 8'h00, 4'(7-k), 0, (k == 7), 0,0,1,0, 3'(k)};

      for (int i = 0; i < 21; i++) apply_vec(i);

      // wrap-around: 5 writes, 5 reads, 6 writes
      mstep("wrap.rst", 0, 0, 0);
      for (int i = 0; i < 5; i++) mstep("wrap.w5", 1, 0, 1);
      for (int i = 0; i < 5; i++) mstep("wrap.r5", 0, 1, 1);
      for (int i = 0; i < 6; i++) mstep("wrap.w6", 1, 0, 1);
      chk("wrap.final_count", int'(data_count), 6);

      // simultaneous at mid-occupancy
      mstep("mid.rst", 0, 0, 0);
      for (int i = 0; i < 3; i++) mstep("mid.fill", 1, 0, 1);
      mstep("mid.both", 1, 1, 1);
      chk("mid.ack_pair", int'({wr_ack, rd_ack}), 3);
      chk("mid.count", int'(data_count), 3);

      // simultaneous at full
      for (int i = 0; i < 5; i++) mstep("full.fill", 1, 0, 1);
      mstep("full.both", 1, 1, 1);
      chk("full.werr_rack", int'({wr_err, rd_ack, wr_ack, rd_err}), 4'b1100);
      chk("full.count", int'(data_count), 7);

      // simultaneous at empty
      for (int i = 0; i < 7; i++) mstep("empty.drain", 0, 1, 1);
      mstep("empty.both", 1, 1, 1);
      chk("empty.wack_rerr", int'({wr_ack, rd_err, wr_err, rd_ack}), 4'b1100);
      chk("empty.count", int'(data_count), 1);

      // reset mid-operation with count=5 and requests pending
      for (int i = 0; i < 4; i++) mstep("rst5.fill", 1, 0, 1);
      chk("rst5.pre_count", int'(data_count), 5);
      mstep("rst5.rst", 1, 1, 0);
      chk("rst5.count", int'(data_count), 0);
      chk("rst5.status", int'({wr_ack, wr_err, rd_ack, rd_err}), 0);

      // random traffic with varying write bias
      begin
         int pw = 50;
         for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) pw = (n / 40) % 3 == 0 ? 80 : ((n / 40) % 3 == 1 ? 20 : 50);
            mstep($sformatf("rnd%0d", n),
                  logic'($urandom_range(0, 99) < pw),
                  logic'($urandom_range(0, 99) < (100 - pw)),
                  logic'($urandom_range(0, 79) != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
